serial_tx: RTL and testbench

Asynchronous serial (UART-style) transmitter: accepts a parallel byte through a valid/ready handshake and shifts it out on a single line as start bit, data bits LSB first, optional parity bit, and stop bit. It is the transmitting end of the serial link that the lab's serial receiver samples. It is built from the same register primitives as the rest of the sequential-logic set: a load register, a shift register, a bit-period counter and a small FSM.

---
 rtl/serial_tx.sv | 126 ++++++++++++
 tb/tb_serial_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - UART-style serial transmitter: start bit, data LSB first, optional parity, stop bit
// Every line level is registered in tx_q, so tx is a single flop output with zero-cycle launch.
module serial_tx #(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8,
  parameter int PARITY  = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign tx       = tx_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the level of the bit that starts at this edge, hence the look-ahead on each transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          par_d   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed bench for serial_tx (CLK_DIV=4, DATA_W=8) with no, even and odd parity
`timescale 1ns/1ps
module tb_serial_tx;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       r0, r1, r2, t0, t1, t2, b0, b1, b2;
  int         tests = 0;
  int         fails = 0;

  serial_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data),
    .tx_valid(v0), .tx_ready(r0), .tx(t0), .busy(b0));
  serial_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data),
    .tx_valid(v1), .tx_ready(r1), .tx(t1), .busy(b1));
  serial_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data),
    .tx_valid(v2), .tx_ready(r2), .tx(t2), .busy(b2));

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    #3 sys_rst_n = 1'b0;
    #1;
    tests++; if (t0 !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", t0); end
    tests++; if (b0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b0); end
    tests++; if (r0 !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", r0); end
    tests++; if ({t1, t2} !== 2'b11) begin fails++; $display("FAIL reset_tx_par got %b want 11", {t1, t2}); end
    tick;
    tick;
    sys_rst_n = 1'b1;
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL reset_idle got tx/busy/ready %b want 101", {t0, b0, r0}); end
  endtask

  task automatic test_single_frame;
    logic [0:9] exp = 10'b0101001011;
    tx_data = 8'hA5; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick;
      tests++; if (t0 !== exp[c/4]) begin fails++; $display("FAIL single_tx cycle %0d got %b want %b", c, t0, exp[c/4]); end
      tests++; if ({b0, r0} !== 2'b10) begin fails++; $display("FAIL single_busy cycle %0d got busy/ready %b want 10", c, {b0, r0}); end
    end
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL single_end got tx/busy/ready %b want 101", {t0, b0, r0}); end
  endtask

  task automatic test_busy_ignore;
    logic [0:9] exp = 10'b0101001011;
    tx_data = 8'hA5; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick;
      if (c == 10) begin tx_data = 8'h3C; v0 = 1'b1; end
      if (c == 14) v0 = 1'b0;
      tests++; if (t0 !== exp[c/4]) begin fails++; $display("FAIL ignore_tx cycle %0d got %b want %b", c, t0, exp[c/4]); end
    end
    for (int c = 0; c < 6; c++) begin
      tick;
      tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL ignore_idle cycle %0d got tx/busy/ready %b want 101", c, {t0, b0, r0}); end
    end
  endtask

  task automatic test_back_to_back;
    logic [0:9] exp1 = 10'b0100000001;
    logic [0:9] exp2 = 10'b0111111111;
    tx_data = 8'h01; v0 = 1'b1;
    tick;
    tx_data = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick;
      tests++; if (t0 !== exp1[c/4]) begin fails++; $display("FAIL b2b_first cycle %0d got %b want %b", c, t0, exp1[c/4]); end
    end
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL b2b_gap got tx/busy/ready %b want 101", {t0, b0, r0}); end
    tick;
    v0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick;
      tests++; if (t0 !== exp2[c/4]) begin fails++; $display("FAIL b2b_second cycle %0d got %b want %b", c, t0, exp2[c/4]); end
    end
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL b2b_end got tx/busy/ready %b want 101", {t0, b0, r0}); end
  endtask

  task automatic test_parity;
    logic [0:10] exp_even = 11'b01110000011;
    logic [0:10] exp_odd  = 11'b01110000001;
    tx_data = 8'h07; v1 = 1'b1; v2 = 1'b1;
    tick;
    v1 = 1'b0; v2 = 1'b0;
    for (int c = 0; c < 44; c++) begin
      if (c > 0) tick;
      tests++; if (t1 !== exp_even[c/4]) begin fails++; $display("FAIL parity_even cycle %0d got %b want %b", c, t1, exp_even[c/4]); end
      tests++; if (t2 !== exp_odd[c/4]) begin fails++; $display("FAIL parity_odd cycle %0d got %b want %b", c, t2, exp_odd[c/4]); end
      tests++; if ({b1, b2} !== 2'b11) begin fails++; $display("FAIL parity_busy cycle %0d got %b want 11", c, {b1, b2}); end
    end
    tick;
    tests++; if ({r1, r2, t1, t2} !== 4'b1111) begin fails++; $display("FAIL parity_end got ready1/ready2/tx1/tx2 %b want 1111", {r1, r2, t1, t2}); end
  endtask

  task automatic test_mid_frame_reset;
    logic [0:9] exp = 10'b0010110101;
    tx_data = 8'h00; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int c = 1; c <= 17; c++) tick;
    tests++; if ({t0, b0} !== 2'b01) begin fails++; $display("FAIL midrst_before got tx/busy %b want 01", {t0, b0}); end
    #1 sys_rst_n = 1'b0;
    v0 = 1'b1;
    #1;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL midrst_instant got tx/busy/ready %b want 101", {t0, b0, r0}); end
    tick;
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL midrst_held got tx/busy/ready %b want 101", {t0, b0, r0}); end
    v0 = 1'b0;
    sys_rst_n = 1'b1;
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL midrst_release got tx/busy/ready %b want 101", {t0, b0, r0}); end
    tx_data = 8'h5A; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick;
      tests++; if (t0 !== exp[c/4]) begin fails++; $display("FAIL midrst_frame cycle %0d got %b want %b", c, t0, exp[c/4]); end
    end
    tick;
    tests++; if ({t0, b0, r0} !== 3'b101) begin fails++; $display("FAIL midrst_end got tx/busy/ready %b want 101", {t0, b0, r0}); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_busy_ignore;
    test_back_to_back;
    test_parity;
    test_mid_frame_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
